// File: rtl/par_bus_bridge.sv
// par_bus_bridge: turns each DataClk toggle of the LPC parallel port into one
// Wishbone-style single access, with read-data capture and sticky error flags.
module par_bus_bridge #(
  parameter int ADR_W   = 8,
  parameter int DAT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             SysClk,
  input  logic             SysRst,
  input  logic             DataClk,
  input  logic             DataWe,
  input  logic [15:0]      DATA,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  output logic             we_o,
  output logic             cyc_o,
  output logic             stb_o,
  input  logic             ack_i,
  input  logic [DAT_W-1:0] dat_i,
  output logic [DAT_W-1:0] rd_dat_o,
  output logic             done_o,
  output logic             err_timeout_o,
  output logic             err_overrun_o,
  input  logic             err_clr
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state_nxt;
  logic r_s1, r_s2, r_s3;
  logic [16:0] r_d1, r_d2;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [ADR_W-1:0] w_adr_nxt;
  logic [DAT_W-1:0] w_dat_nxt, w_rd_nxt;
  logic w_we_nxt, w_cyc_nxt, w_done_nxt, w_to_nxt, w_ov_nxt;
  logic w_tog, w_to_hit;
  assign w_tog    = r_s2 ^ r_s3;
  assign w_to_hit = r_cnt >= CW'(TIMEOUT - 1);
  assign stb_o    = cyc_o;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_adr_nxt   = adr_o;
    w_dat_nxt   = dat_o;
    w_we_nxt    = we_o;
    w_cyc_nxt   = cyc_o;
    w_rd_nxt    = rd_dat_o;
    w_done_nxt  = 1'b0;
    w_to_nxt    = err_timeout_o;
    w_ov_nxt    = err_overrun_o;
    if (r_state == IDLE) begin
      if (w_tog) begin
        w_adr_nxt   = r_d2[8 +: ADR_W];
        w_dat_nxt   = r_d2[0 +: DAT_W];
        w_we_nxt    = r_d2[16];
        w_cyc_nxt   = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = BUSY;
      end
    end else begin
      // a toggle while busy is dropped, even on the completing cycle
      w_ov_nxt = err_overrun_o | w_tog;
      if (ack_i) begin
        w_cyc_nxt   = 1'b0;
        w_done_nxt  = 1'b1;
        w_rd_nxt    = we_o ? rd_dat_o : dat_i;
        w_state_nxt = IDLE;
      end else if (w_to_hit) begin
        w_cyc_nxt   = 1'b0;
        w_done_nxt  = 1'b1;
        w_to_nxt    = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        w_cnt_nxt = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;
      end
    end
    if (err_clr) begin
      w_to_nxt = 1'b0;
      w_ov_nxt = 1'b0;
    end
  end
  always_ff @(posedge SysClk) begin
    if (!SysRst) begin
      r_s1          <= DataClk;
      r_s2          <= DataClk;
      r_s3          <= DataClk;
      r_d1          <= '0;
      r_d2          <= '0;
      r_state       <= IDLE;
      r_cnt         <= '0;
      adr_o         <= '0;
      dat_o         <= '0;
      we_o          <= 1'b0;
      cyc_o         <= 1'b0;
      rd_dat_o      <= '0;
      done_o        <= 1'b0;
      err_timeout_o <= 1'b0;
      err_overrun_o <= 1'b0;
    end else begin
      r_s1          <= DataClk;
      r_s2          <= r_s1;
      r_s3          <= r_s2;
      r_d1          <= {DataWe, DATA};
      r_d2          <= r_d1;
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      adr_o         <= w_adr_nxt;
      dat_o         <= w_dat_nxt;
      we_o          <= w_we_nxt;
      cyc_o         <= w_cyc_nxt;
      rd_dat_o      <= w_rd_nxt;
      done_o        <= w_done_nxt;
      err_timeout_o <= w_to_nxt;
      err_overrun_o <= w_ov_nxt;
    end
  end
endmodule

// File: tb/tb_par_bus_bridge.sv
// tb_par_bus_bridge: vector table plus corner sequences; a negedge monitor
// checks each bus cycle against expectations queued when the toggle is driven.
module tb_par_bus_bridge;
  logic SysClk = 0, SysRst = 0, DataClk = 0, DataWe = 0, ack_i = 0, err_clr = 0;
  logic [15:0] DATA = '0;
  logic [7:0] dat_i = '0;
  logic [7:0] adr_o, dat_o, rd_dat_o;
  logic we_o, cyc_o, stb_o, done_o, err_timeout_o, err_overrun_o;

  par_bus_bridge dut (
    .SysClk(SysClk), .SysRst(SysRst), .DataClk(DataClk), .DataWe(DataWe), .DATA(DATA),
    .adr_o(adr_o), .dat_o(dat_o), .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .ack_i(ack_i), .dat_i(dat_i), .rd_dat_o(rd_dat_o), .done_o(done_o),
    .err_timeout_o(err_timeout_o), .err_overrun_o(err_overrun_o), .err_clr(err_clr)
  );

  always #5 SysClk = ~SysClk;

  typedef struct packed {logic [7:0] adr; logic [7:0] dat; logic we;} exp_t;
  typedef struct {logic [15:0] data; logic we; int dly; logic [7:0] rd; logic [7:0] exp_rd;} vec_t;
  exp_t q[$];
  exp_t m_e;
  vec_t vt[6];
  int n_tests = 0, n_fail = 0, n_done = 0, n_cyc = 0;
  logic prev_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge SysClk) begin
    if (done_o) n_done++;
    if (cyc_o && !prev_cyc) begin
      n_cyc++;
      chk("cycle expected", q.size(), 1);
      if (q.size() != 0) begin
        m_e = q.pop_front();
        chk("cyc adr", adr_o, m_e.adr);
        chk("cyc dat", dat_o, m_e.dat);
        chk("cyc we", we_o, m_e.we);
        chk("stb eq cyc", stb_o, 1);
      end
    end
    prev_cyc = cyc_o;
  end

  task automatic toggle(input logic [15:0] d, input logic we);
    exp_t e;
    DATA = d;
    DataWe = we;
    repeat (4) @(negedge SysClk);
    DataClk = ~DataClk;
    e = '{d[15:8], d[7:0], we};
    q.push_back(e);
    repeat (2) @(negedge SysClk);
    chk("stb early", cyc_o, 0);
    @(negedge SysClk);
    chk("stb latency", cyc_o, 1);
  endtask

  task automatic access(input logic [15:0] d, input logic we, input int dly, input logic [7:0] rd);
    int d0 = n_done;
    toggle(d, we);
    repeat (dly - 1) @(negedge SysClk);
    ack_i = 1;
    dat_i = rd;
    @(negedge SysClk);
    ack_i = 0;
    dat_i = ~rd;
    chk("cyc drop on ack", cyc_o, 0);
    chk("done on ack", done_o, 1);
    @(negedge SysClk);
    chk("done one cycle", done_o, 0);
    chk("done count", n_done, d0 + 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, c0, cnt;
    logic [7:0] rd0;
    vt[0] = '{16'h8101, 1'b1, 2,  8'h00, 8'h00};
    vt[1] = '{16'h0400, 1'b0, 1,  8'h3F, 8'h3F};
    vt[2] = '{16'h1234, 1'b1, 3,  8'h99, 8'h3F};
    vt[3] = '{16'h55AA, 1'b0, 15, 8'hC3, 8'hC3};
    vt[4] = '{16'hFF00, 1'b0, 1,  8'h00, 8'h00};
    vt[5] = '{16'h00FF, 1'b1, 14, 8'h5A, 8'h00};
    repeat (3) @(negedge SysClk);
    chk("reset outputs", {2'b0, adr_o, dat_o, we_o, cyc_o, stb_o, rd_dat_o, done_o, err_timeout_o, err_overrun_o}, 0);
    SysRst = 1;
    repeat (4) @(negedge SysClk);
    chk("no cycle after reset", n_cyc, 0);
    foreach (vt[i]) begin
      access(vt[i].data, vt[i].we, vt[i].dly, vt[i].rd);
      chk("adr hold", adr_o, {24'h0, vt[i].data[15:8]});
      chk("dat hold", dat_o, {24'h0, vt[i].data[7:0]});
      chk("we hold", we_o, vt[i].we);
      chk("rd_dat", rd_dat_o, vt[i].exp_rd);
      chk("no timeout err", err_timeout_o, 0);
      chk("no overrun err", err_overrun_o, 0);
      repeat (3) @(negedge SysClk);
    end
    // timeout: no ack at all
    rd0 = rd_dat_o;
    d0 = n_done;
    toggle(16'h2233, 1'b0);
    cnt = 1;
    for (int i = 0; i < 40 && cyc_o; i++) begin
      @(negedge SysClk);
      if (cyc_o) cnt++;
    end
    chk("stb cycles on timeout", cnt, 15);
    chk("done on timeout", done_o, 1);
    chk("err_timeout set", err_timeout_o, 1);
    chk("rd unchanged on timeout", rd_dat_o, rd0);
    @(negedge SysClk);
    chk("timeout done count", n_done, d0 + 1);
    err_clr = 1;
    @(negedge SysClk);
    err_clr = 0;
    chk("err_timeout cleared", err_timeout_o, 0);
    // overrun: second toggle 2 cycles after the first
    c0 = n_cyc;
    DATA = 16'h4455;
    DataWe = 1;
    repeat (4) @(negedge SysClk);
    DataClk = ~DataClk;
    q.push_back('{8'h44, 8'h55, 1'b1});
    repeat (2) @(negedge SysClk);
    DataClk = ~DataClk;
    @(negedge SysClk);
    chk("overrun first stb", cyc_o, 1);
    repeat (4) @(negedge SysClk);
    ack_i = 1;
    @(negedge SysClk);
    ack_i = 0;
    repeat (8) @(negedge SysClk);
    chk("overrun single cycle", n_cyc, c0 + 1);
    chk("err_overrun set", err_overrun_o, 1);
    chk("overrun no timeout", err_timeout_o, 0);
    chk("overrun queue empty", q.size(), 0);
    err_clr = 1;
    @(negedge SysClk);
    err_clr = 0;
    chk("err_overrun cleared", err_overrun_o, 0);
    // back-to-back writes, alternating DataClk polarity
    c0 = n_cyc;
    rd0 = rd_dat_o;
    for (int i = 0; i < 8; i++) begin
      access({8'h10 + 8'(i), 8'hA0 + 8'(i)}, 1'b1, 2, 8'hFF);
      repeat (5) @(negedge SysClk);
    end
    chk("b2b cycles", n_cyc, c0 + 8);
    chk("b2b errors", {err_timeout_o, err_overrun_o}, 0);
    chk("b2b rd unchanged", rd_dat_o, rd0);
    // reset in the middle of an access, released with DataClk high
    toggle(16'h6677, 1'b1);
    d0 = n_done;
    SysRst = 0;
    DataClk = 1;
    @(negedge SysClk);
    chk("mid-busy reset outputs", {2'b0, adr_o, dat_o, we_o, cyc_o, stb_o, rd_dat_o, done_o, err_timeout_o, err_overrun_o}, 0);
    repeat (2) @(negedge SysClk);
    c0 = n_cyc;
    SysRst = 1;
    repeat (10) @(negedge SysClk);
    chk("no spurious cycle", n_cyc, c0);
    chk("no done after reset", n_done, d0);
    chk("idle after reset", cyc_o, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
